next_queue: RTL

Next-piece queue sitting directly downstream of the 7-bag randomiser in the controller. It requests fresh bags with `newbag`, captures each completed 21-bit bag on `bag_done`, and unpacks it into a circular FIFO of 3-bit piece codes. It serves pieces to the game FSM through a valid/pop handshake and drives a fixed-depth preview for the next-piece display.

---
 rtl/next_queue.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/next_queue.sv
// Next-piece queue: requests 7-bags, unpacks them into a circular FIFO of
// 3-bit piece codes, and serves head + preview. Optional bag check: NEXT_QUEUE_CHECK_EN.
module next_queue #(
    parameter int DEPTH   = 14,
    parameter int PREVIEW = 3
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   bag_done,
    input  logic [20:0]            bag,
    input  logic                   pop,
    output logic                   newbag,
    output logic                   piece_valid,
    output logic [2:0]             piece,
    output logic [3*PREVIEW-1:0]   preview,
    output logic [4:0]             count,
    output logic                   bag_err
);

    // state  | meaning
    // S_IDLE | waiting for room for a whole bag (count <= DEPTH-7)
    // S_REQ  | newbag pulse, one cycle
    // S_WAIT | waiting for bag_done; first cycle ignored while the bag clears
    // S_LOAD | writing field k of bag_q at tail, k = 0..6
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_LOAD = 2'd3
    } state_t;

    localparam logic [4:0] LOW_MARK = 5'(DEPTH - 7);
    localparam logic [4:0] DEPTH_W  = 5'(DEPTH);
    localparam logic [3:0] LAST     = 4'(DEPTH - 1);

    state_t      state;
    logic        wait_first;
    logic [2:0]  k;
    logic [20:0] bag_q;
    logic [3:0]  head;
    logic [3:0]  tail;
    logic [2:0]  mem [16];

    logic        pop_ok;
    logic        load_wr;
    logic [2:0]  wr_data;
    logic        bag_ok;
    logic        bag_take;
    logic [4:0]  pidx;

    assign pop_ok   = pop && (count != 5'd0);
    assign load_wr  = (state == S_LOAD);
    assign wr_data  = 3'(bag_q >> (5'(k) * 5'd3));
    assign bag_take = (state == S_WAIT) && !wait_first && bag_done;

`ifdef NEXT_QUEUE_CHECK_EN
    logic [6:0] seen;

    // A legal bag marks each of the seven codes exactly once.
    always_comb begin
        seen = '0;
        for (int i = 0; i < 7; i++) begin
            if (bag[3*i +: 3] != 3'b111) begin
                seen[bag[3*i +: 3]] = 1'b1;
            end
        end
        bag_ok = &seen;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bag_err <= 1'b0;
        end else if (bag_take && !bag_ok) begin
            bag_err <= 1'b1;
        end
    end
`else
    assign bag_ok  = 1'b1;
    assign bag_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= S_IDLE;
            wait_first <= 1'b0;
            k          <= 3'd0;
            bag_q      <= '0;
            head       <= 4'd0;
            tail       <= 4'd0;
            count      <= 5'd0;
            newbag     <= 1'b0;
        end else begin
            newbag <= 1'b0;
            if (pop_ok) begin
                head <= (head == LAST) ? 4'd0 : head + 4'd1;
            end
            if (load_wr) begin
                tail <= (tail == LAST) ? 4'd0 : tail + 4'd1;
            end
            count <= count + 5'(load_wr) - 5'(pop_ok);

            unique case (state)
                S_IDLE: begin
                    if (count <= LOW_MARK) begin
                        state  <= S_REQ;
                        newbag <= 1'b1;
                    end
                end
                S_REQ: begin
                    state      <= S_WAIT;
                    wait_first <= 1'b1;
                end
                S_WAIT: begin
                    wait_first <= 1'b0;
                    if (bag_take) begin
                        if (bag_ok) begin
                            bag_q <= bag;
                            k     <= 3'd0;
                            state <= S_LOAD;
                        end else begin
                            state  <= S_REQ;
                            newbag <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    k <= k + 3'd1;
                    if (k == 3'd6) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Array contents need no reset: every read is gated by count.
    always_ff @(posedge clk) begin
        if (load_wr) begin
            mem[tail] <= wr_data;
        end
    end

    assign piece_valid = (count != 5'd0);
    assign piece       = piece_valid ? mem[head] : 3'b111;

    always_comb begin
        preview = '1;
        pidx    = '0;
        for (int j = 0; j < PREVIEW; j++) begin
            pidx = 5'(head) + 5'(j + 1);
            if (pidx >= DEPTH_W) begin
                pidx = pidx - DEPTH_W;
            end
            if (count > 5'(j + 1)) begin
                preview[3*j +: 3] = mem[4'(pidx)];
            end
        end
    end

endmodule
